id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline. It consumes the IF/ID latch (instruction word and PC+4 from the fetch stage) and holds the 32×32 register file, written back from MEM/WB. It decodes the main control vector and sign-extends the immediate. It registers everything into the ID/EX latch one clock later. With the hazard option compiled in, it also detects load-use hazards and inserts bubbles.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/reg_file.sv | 41 ++++
 rtl/id_stage.sv | 79 +++++++
 tb/tb_id_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, control-vector widths, bit positions and the
// main control decoder used by the ID stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 3;
  localparam int unsigned EX_W = 4;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned M_BRANCH    = 2;
  localparam int unsigned M_MEMREAD   = 1;
  localparam int unsigned M_MEMWRITE  = 0;
  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE] = 1'b1;
        c.ex[EX_REGDST]   = 1'b1;
        c.ex[EX_ALUOP_HI] = 1'b1;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE] = 1'b1;
        c.wb[WB_MEMTOREG] = 1'b1;
        c.m[M_MEMREAD]    = 1'b1;
        c.ex[EX_ALUSRC]   = 1'b1;
      end
      OP_SW: begin
        c.m[M_MEMWRITE] = 1'b1;
        c.ex[EX_ALUSRC] = 1'b1;
      end
      OP_BEQ: begin
        c.m[M_BRANCH]     = 1'b1;
        c.ex[EX_ALUOP_LO] = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: synchronous clear, $0 hardwired to zero, two combinational read
// ports with write-before-read bypass from the write-back port.
module reg_file (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs_q [32];
  logic        wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != 5'd0) begin
      rs_data = (wr_live && (wr_addr == rs_addr)) ? wr_data : regs_q[rs_addr];
    end
    if (rt_addr != 5'd0) begin
      rt_data = (wr_live && (wr_addr == rt_addr)) ? wr_data : regs_q[rt_addr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, sign-extend, register file and ID/EX latch.
// Define ID_STAGE_HAZARD_EN to enable load-use stall detection and bubble insertion.
module id_stage
  import mips_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     IF_ID_inst,
  input  logic [7:0]      IF_ID_npc,
  input  logic            MEM_WB_RegWrite,
  input  logic [4:0]      MEM_WB_WriteReg,
  input  logic [31:0]     WB_WriteData,
  output logic [WB_W-1:0] ID_EX_wb,
  output logic [M_W-1:0]  ID_EX_m,
  output logic [EX_W-1:0] ID_EX_ex,
  output logic [31:0]     ID_EX_npc,
  output logic [31:0]     ID_EX_readdat1,
  output logic [31:0]     ID_EX_readdat2,
  output logic [31:0]     ID_EX_sign_ext,
  output logic [4:0]      ID_EX_instr_2016,
  output logic [4:0]      ID_EX_instr_1511,
  output logic            stall
);

  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data, sign_ext;
  ctrl_t       dec_ctrl;

  assign rs       = IF_ID_inst[25:21];
  assign rt       = IF_ID_inst[20:16];
  assign rd       = IF_ID_inst[15:11];
  assign sign_ext = {{16{IF_ID_inst[15]}}, IF_ID_inst[15:0]};
  assign dec_ctrl = decode_ctrl(IF_ID_inst[31:26]);

  reg_file u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wr_en   (MEM_WB_RegWrite),
    .wr_addr (MEM_WB_WriteReg),
    .wr_data (WB_WriteData)
  );

`ifdef ID_STAGE_HAZARD_EN
  // Gated by reset so stall is clean before the ID/EX latch has been cleared.
  assign stall = !reset && ID_EX_m[M_MEMREAD] && (ID_EX_instr_2016 != 5'd0) &&
                 ((ID_EX_instr_2016 == rs) || (ID_EX_instr_2016 == rt));
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ID_EX_wb         <= '0;
      ID_EX_m          <= '0;
      ID_EX_ex         <= '0;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      ID_EX_wb         <= stall ? '0 : dec_ctrl.wb;
      ID_EX_m          <= stall ? '0 : dec_ctrl.m;
      ID_EX_ex         <= stall ? '0 : dec_ctrl.ex;
      ID_EX_npc        <= {24'd0, IF_ID_npc};
      ID_EX_readdat1   <= rs_data;
      ID_EX_readdat2   <= rt_data;
      ID_EX_sign_ext   <= sign_ext;
      ID_EX_instr_2016 <= rt;
      ID_EX_instr_1511 <= rd;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed test-plan cases followed by random traffic,
// all compared against a table-driven reference model of the decode stage.
module tb_id_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IF_ID_inst;
  logic [7:0]  IF_ID_npc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016, ID_EX_instr_1511;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  id_stage dut (
    .clock            (clock),
    .reset            (reset),
    .IF_ID_inst       (IF_ID_inst),
    .IF_ID_npc        (IF_ID_npc),
    .MEM_WB_RegWrite  (MEM_WB_RegWrite),
    .MEM_WB_WriteReg  (MEM_WB_WriteReg),
    .WB_WriteData     (WB_WriteData),
    .ID_EX_wb         (ID_EX_wb),
    .ID_EX_m          (ID_EX_m),
    .ID_EX_ex         (ID_EX_ex),
    .ID_EX_npc        (ID_EX_npc),
    .ID_EX_readdat1   (ID_EX_readdat1),
    .ID_EX_readdat2   (ID_EX_readdat2),
    .ID_EX_sign_ext   (ID_EX_sign_ext),
    .ID_EX_instr_2016 (ID_EX_instr_2016),
    .ID_EX_instr_1511 (ID_EX_instr_1511),
    .stall            (stall)
  );

  // Reference model state
  logic [31:0] m_regs [32];
  logic [8:0]  e_ctrl;
  logic [31:0] e_npc, e_rd1, e_rd2, e_sext;
  logic [4:0]  e_rt, e_rd;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // {wb[1:0], m[2:0], ex[3:0]} straight from the opcode table
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b00_000_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa != 0 && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic cycle(input logic rst, input logic [31:0] inst, input logic [7:0] npc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0]  rs, rt;
    logic        hz, exp_stall;
    logic [31:0] r1, r2;
    reset = rst; IF_ID_inst = inst; IF_ID_npc = npc;
    MEM_WB_RegWrite = we; MEM_WB_WriteReg = wa; WB_WriteData = wd;
    rs = inst[25:21];
    rt = inst[20:16];
`ifdef ID_STAGE_HAZARD_EN
    hz = 1'b1;
`else
    hz = 1'b0;
`endif
    exp_stall = hz && !rst && e_ctrl[5] && e_rt != 0 && (e_rt == rs || e_rt == rt);
    r1 = ref_read(rs, we, wa, wd);
    r2 = ref_read(rt, we, wa, wd);
    #2;
    last_stall = stall;
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clock);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      e_ctrl = '0; e_npc = '0; e_rd1 = '0; e_rd2 = '0; e_sext = '0; e_rt = '0; e_rd = '0;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      e_ctrl = exp_stall ? 9'd0 : ref_ctrl(inst[31:26]);
      e_npc  = 32'(npc);
      e_rd1  = r1;
      e_rd2  = r2;
      e_sext = 32'($signed(inst[15:0]));
      e_rt   = rt;
      e_rd   = inst[15:11];
    end
    check("wb", 32'(ID_EX_wb), 32'(e_ctrl[8:7]));
    check("m", 32'(ID_EX_m), 32'(e_ctrl[6:4]));
    check("ex", 32'(ID_EX_ex), 32'(e_ctrl[3:0]));
    check("npc", ID_EX_npc, e_npc);
    check("rd1", ID_EX_readdat1, e_rd1);
    check("rd2", ID_EX_readdat2, e_rd2);
    check("sext", ID_EX_sign_ext, e_sext);
    check("rt", 32'(ID_EX_instr_2016), 32'(e_rt));
    check("rd", 32'(ID_EX_instr_1511), 32'(e_rd));
  endtask

  initial begin
    logic [5:0]  ops [5];
    logic [31:0] inst;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    e_ctrl = '0; e_npc = '0; e_rd1 = '0; e_rd2 = '0; e_sext = '0; e_rt = '0; e_rd = '0;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h3F;

    // Reset with a competing write-back to $5
    cycle(1'b1, 32'h00000000, 8'h00, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle(1'b1, 32'h00000000, 8'h00, 1'b1, 5'd5, 32'hDEADBEEF);
    check("rst_wb", 32'(ID_EX_wb), 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    cycle(1'b0, 32'h00A50000, 8'h04, 1'b0, 5'd0, 32'd0);
    check("rst_r5", ID_EX_readdat1, 32'd0);

    // Load decode
    cycle(1'b0, 32'h00000000, 8'h08, 1'b1, 5'd8, 32'h000000AA);
    cycle(1'b0, 32'h8D090004, 8'h0C, 1'b0, 5'd0, 32'd0);
    check("lw_wb", 32'(ID_EX_wb), 32'd3);
    check("lw_m", 32'(ID_EX_m), 32'd2);
    check("lw_ex", 32'(ID_EX_ex), 32'd1);
    check("lw_rd1", ID_EX_readdat1, 32'hAA);
    check("lw_sext", ID_EX_sign_ext, 32'h4);
    check("lw_rt", 32'(ID_EX_instr_2016), 32'd9);
    check("lw_npc", ID_EX_npc, 32'h0000000C);

    // Same-cycle write-back bypass
    cycle(1'b0, 32'h00630820, 8'h10, 1'b1, 5'd3, 32'h00001234);
    check("byp_rd1", ID_EX_readdat1, 32'h1234);
    check("byp_rd2", ID_EX_readdat2, 32'h1234);
    check("byp_wb", 32'(ID_EX_wb), 32'd2);
    check("byp_ex", 32'(ID_EX_ex), 32'hC);
    check("byp_rd", 32'(ID_EX_instr_1511), 32'd1);

    // $0 protection
    cycle(1'b0, 32'h00000000, 8'h14, 1'b1, 5'd0, 32'hFFFFFFFF);
    cycle(1'b0, 32'h00000820, 8'h18, 1'b0, 5'd0, 32'd0);
    check("z_rd1", ID_EX_readdat1, 32'd0);
    check("z_rd2", ID_EX_readdat2, 32'd0);

    // Branch with negative offset
    cycle(1'b0, 32'h1022FFFC, 8'h1C, 1'b0, 5'd0, 32'd0);
    check("beq_sext", ID_EX_sign_ext, 32'hFFFFFFFC);
    check("beq_m", 32'(ID_EX_m), 32'd4);
    check("beq_wb", 32'(ID_EX_wb), 32'd0);
    check("beq_ex", 32'(ID_EX_ex), 32'd2);

    // Load-use: fetch holds the dependent add while stalled
    cycle(1'b0, 32'h8D090004, 8'h20, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 32'h01295020, 8'h24, 1'b0, 5'd0, 32'd0);
`ifdef ID_STAGE_HAZARD_EN
    check("lu_stall", {31'd0, last_stall}, 32'd1);
    check("lu_bub_wb", 32'(ID_EX_wb), 32'd0);
    check("lu_bub_m", 32'(ID_EX_m), 32'd0);
    check("lu_bub_ex", 32'(ID_EX_ex), 32'd0);
    cycle(1'b0, 32'h01295020, 8'h24, 1'b0, 5'd0, 32'd0);
    check("lu_clear", {31'd0, last_stall}, 32'd0);
`else
    check("lu_nostall", {31'd0, last_stall}, 32'd0);
`endif
    check("lu_add_wb", 32'(ID_EX_wb), 32'd2);
    check("lu_add_ex", 32'(ID_EX_ex), 32'hC);

    // Random traffic over a small register window to provoke hazards and bypasses
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      inst[31:26] = ops[$urandom_range(0, 4)];
      inst[25:21] = 5'($urandom_range(0, 7));
      inst[20:16] = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 39) == 0), inst, 8'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
